writeback_unit: RTL and testbench

- Final stage ahead of the integer register file.
- Accepts retiring results from the execute unit (EXU) and load data returned by the load/store unit (LSU).
- Performs load byte/half selection and sign or zero extension, then drives the register file's single write port through registered outputs.
- Exports a read-after-write stall signal to decode for pending loads and in-flight writes.

---
 rtl/writeback_unit_pkg.sv | 19 +
 rtl/writeback_unit_load_extract.sv | 52 +++++
 rtl/writeback_unit.sv | 143 ++++++++++++++
 tb/tb_writeback_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes, FSM state type and
// default widths.
package writeback_unit_pkg;

    localparam int unsigned DataWidthDef = 32;
    localparam int unsigned AddrWidthDef = 5;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_MEM
    } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_extract.sv
// Combinational load data extraction: selects byte/half/word from an aligned memory word,
// extends it, and flags illegal funct3 codes and misaligned accesses.
module load_extract
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidthDef
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  illegal,
    output logic                  misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        value      = '0;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            Funct3Lb:  value = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            Funct3Lbu: value = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            Funct3Lh: begin
                value      = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            Funct3Lhu: begin
                value      = {{(DATA_WIDTH-16){1'b0}}, half_sel};
                misaligned = addr_lo[0];
            end
            Funct3Lw: begin
                value      = rdata;
                misaligned = (addr_lo != 2'd0);
            end
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires EXU results and LSU load returns onto the register file write
// port through registered outputs, and raises a read-after-write stall for decode.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidthDef,
    parameter int unsigned ADDR_WIDTH = AddrWidthDef
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic                  exu_wen,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  exu_is_load,
    input  logic [2:0]            exu_ld_funct3,
    input  logic [1:0]            exu_addr_lo,
    input  logic                  lsu_rvalid,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,
    input  logic                  lsu_rerr,
    input  logic [ADDR_WIDTH-1:0] hz_raddr1,
    input  logic [ADDR_WIDTH-1:0] hz_raddr2,
    output logic                  hz_stall,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  wb_done,
    output logic                  wb_err
);

    wb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
    logic                  ld_wen_q, ld_wen_d;
    logic [2:0]            ld_funct3_q, ld_funct3_d;
    logic [1:0]            ld_addr_lo_q, ld_addr_lo_d;

    logic                  rf_wen_d, wb_done_d, wb_err_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_d;

    logic [DATA_WIDTH-1:0] ld_value;
    logic                  ld_illegal, ld_misaligned;

    load_extract #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extract (
        .funct3     (ld_funct3_q),
        .addr_lo    (ld_addr_lo_q),
        .rdata      (lsu_rdata),
        .value      (ld_value),
        .illegal    (ld_illegal),
        .misaligned (ld_misaligned)
    );

    assign exu_ready = (state_q == IDLE);

    always_comb begin
        state_d      = state_q;
        ld_rd_d      = ld_rd_q;
        ld_wen_d     = ld_wen_q;
        ld_funct3_d  = ld_funct3_q;
        ld_addr_lo_d = ld_addr_lo_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = '0;
        rf_wdata_d   = '0;
        wb_done_d    = 1'b0;
        wb_err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (exu_valid) begin
                    if (exu_is_load) begin
                        ld_rd_d      = exu_rd;
                        ld_wen_d     = exu_wen;
                        ld_funct3_d  = exu_ld_funct3;
                        ld_addr_lo_d = exu_addr_lo;
                        state_d      = WAIT_MEM;
                    end else begin
                        rf_wen_d   = exu_wen && (exu_rd != '0);
                        rf_waddr_d = exu_rd;
                        rf_wdata_d = exu_data;
                        wb_done_d  = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (lsu_rvalid) begin
                    state_d    = IDLE;
                    wb_done_d  = 1'b1;
                    rf_waddr_d = ld_rd_q;
                    // Faulting loads retire with an error pulse and never touch the register.
                    if (lsu_rerr || ld_illegal || ld_misaligned) begin
                        wb_err_d = 1'b1;
                    end else begin
                        rf_wen_d   = ld_wen_q && (ld_rd_q != '0);
                        rf_wdata_d = ld_value;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ld_rd_q      <= '0;
            ld_wen_q     <= 1'b0;
            ld_funct3_q  <= '0;
            ld_addr_lo_q <= '0;
            rf_wen       <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            wb_done      <= 1'b0;
            wb_err       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_rd_q      <= ld_rd_d;
            ld_wen_q     <= ld_wen_d;
            ld_funct3_q  <= ld_funct3_d;
            ld_addr_lo_q <= ld_addr_lo_d;
            rf_wen       <= rf_wen_d;
            rf_waddr     <= rf_waddr_d;
            rf_wdata     <= rf_wdata_d;
            wb_done      <= wb_done_d;
            wb_err       <= wb_err_d;
        end
    end

    // rf_wen is already gated by rd != 0, so register 0 can never stall.
    always_comb begin
        hz_stall = 1'b0;
        if (state_q == WAIT_MEM && ld_wen_q && ld_rd_q != '0 &&
            (hz_raddr1 == ld_rd_q || hz_raddr2 == ld_rd_q)) begin
            hz_stall = 1'b1;
        end
        if (rf_wen && (hz_raddr1 == rf_waddr || hz_raddr2 == rf_waddr)) begin
            hz_stall = 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by randomized traffic,
// all compared against a transaction-level reference model.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, exu_ready, exu_wen, exu_is_load;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic [2:0]  exu_ld_funct3;
    logic [1:0]  exu_addr_lo;
    logic        lsu_rvalid, lsu_rerr;
    logic [31:0] lsu_rdata;
    logic [4:0]  hz_raddr1, hz_raddr2;
    logic        hz_stall, rf_wen, wb_done, wb_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    writeback_unit dut (
        .clk           (clk),
        .rst           (rst),
        .exu_valid     (exu_valid),
        .exu_ready     (exu_ready),
        .exu_rd        (exu_rd),
        .exu_wen       (exu_wen),
        .exu_data      (exu_data),
        .exu_is_load   (exu_is_load),
        .exu_ld_funct3 (exu_ld_funct3),
        .exu_addr_lo   (exu_addr_lo),
        .lsu_rvalid    (lsu_rvalid),
        .lsu_rdata     (lsu_rdata),
        .lsu_rerr      (lsu_rerr),
        .hz_raddr1     (hz_raddr1),
        .hz_raddr2     (hz_raddr2),
        .hz_stall      (hz_stall),
        .rf_wen        (rf_wen),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .wb_done       (wb_done),
        .wb_err        (wb_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one outstanding load record plus the expected registered outputs.
    bit          m_pend = 0, m_pwen = 0;
    bit [4:0]    m_prd = 0;
    bit [2:0]    m_pf3 = 0;
    bit [1:0]    m_poff = 0;
    bit          m_wen = 0, m_done = 0, m_err = 0, m_full = 0;
    bit [4:0]    m_waddr = 0;
    bit [31:0]   m_wdata = 0;
    bit          last_ready = 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Load semantics written as shifts and masks on the returned word.
    task automatic ref_load(input bit [2:0] f3, input bit [1:0] off, input bit [31:0] word,
                            output bit [31:0] val, output bit bad);
        bit [31:0] b, h;
        b   = (word >> (8 * off)) & 32'hFF;
        h   = (word >> (16 * (off / 2))) & 32'hFFFF;
        bad = 0;
        val = 0;
        case (f3)
            3'd0: val = (b >= 128) ? b - 32'd256 : b;
            3'd4: val = b;
            3'd1: begin val = (h >= 32768) ? h - 32'd65536 : h; bad = (off % 2) != 0; end
            3'd5: begin val = h; bad = (off % 2) != 0; end
            3'd2: begin val = word; bad = off != 0; end
            default: bad = 1;
        endcase
    endtask

    task automatic tick();
        bit        exp_ready, exp_stall, bad;
        bit [31:0] val;
        @(negedge clk);
        exp_ready = !m_pend;
        exp_stall = (m_pend && m_pwen && m_prd != 0 &&
                     (hz_raddr1 == m_prd || hz_raddr2 == m_prd)) ||
                    (m_wen && (hz_raddr1 == m_waddr || hz_raddr2 == m_waddr));
        check_eq("exu_ready", {31'd0, exu_ready}, {31'd0, exp_ready});
        check_eq("hz_stall", {31'd0, hz_stall}, {31'd0, exp_stall});
        last_ready = exp_ready;

        m_wen = 0; m_done = 0; m_err = 0; m_full = 0; m_waddr = 0; m_wdata = 0;
        if (rst) begin
            m_pend = 0;
            m_full = 1;
        end else if (!m_pend) begin
            if (exu_valid && exu_is_load) begin
                m_pend = 1; m_prd = exu_rd; m_pwen = exu_wen;
                m_pf3 = exu_ld_funct3; m_poff = exu_addr_lo;
            end else if (exu_valid) begin
                m_wen = exu_wen && exu_rd != 0; m_waddr = exu_rd; m_wdata = exu_data;
                m_done = 1; m_full = 1;
            end
        end else if (lsu_rvalid) begin
            ref_load(m_pf3, m_poff, lsu_rdata, val, bad);
            m_pend = 0;
            m_done = 1;
            if (lsu_rerr || bad) begin
                m_err = 1;
            end else begin
                m_wen = m_pwen && m_prd != 0; m_waddr = m_prd; m_wdata = val; m_full = m_wen;
            end
        end

        @(posedge clk);
        #1;
        check_eq("rf_wen", {31'd0, rf_wen}, {31'd0, m_wen});
        check_eq("wb_done", {31'd0, wb_done}, {31'd0, m_done});
        check_eq("wb_err", {31'd0, wb_err}, {31'd0, m_err});
        if (m_full) begin
            check_eq("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
            check_eq("rf_wdata", rf_wdata, m_wdata);
        end
    endtask

    task automatic idle();
        exu_valid = 0; lsu_rvalid = 0; lsu_rerr = 0;
    endtask

    task automatic exu(input bit [4:0] rd, input bit wen, input bit [31:0] data,
                       input bit ld, input bit [2:0] f3, input bit [1:0] off);
        exu_valid = 1; exu_rd = rd; exu_wen = wen; exu_data = data;
        exu_is_load = ld; exu_ld_funct3 = f3; exu_addr_lo = off;
    endtask

    // Issue a load, let it wait, return data together with a competing EXU result.
    task automatic do_load(input bit [4:0] rd, input bit [2:0] f3, input bit [1:0] off,
                           input bit [31:0] word, input bit err, input bit [4:0] hz);
        exu(rd, 1, 32'h5555_AAAA, 1, f3, off);
        hz_raddr1 = hz; hz_raddr2 = 0;
        tick();
        idle(); tick(); tick();
        lsu_rvalid = 1; lsu_rdata = word; lsu_rerr = err;
        exu(5'd9, 1, 32'hC0DE_0009, 0, 3'd0, 2'd0);
        tick();
        lsu_rvalid = 0; lsu_rerr = 0;
        tick();
        idle(); tick();
    endtask

    initial begin
        rst = 1; hz_raddr1 = 0; hz_raddr2 = 0; lsu_rdata = 0;
        exu(0, 0, 0, 0, 0, 0);
        idle();
        @(posedge clk);
        #1;
        tick();
        rst = 0;

        exu(5'd5, 1, 32'hDEAD_BEEF, 0, 3'd0, 2'd0); tick();
        idle(); tick();
        exu(5'd0, 1, 32'h0000_1234, 0, 3'd0, 2'd0); tick();
        exu(5'd1, 1, 32'h1111_1111, 0, 3'd0, 2'd0); hz_raddr2 = 5'd1; tick();
        exu(5'd2, 1, 32'h2222_2222, 0, 3'd0, 2'd0); tick();
        idle(); hz_raddr2 = 0; lsu_rvalid = 1; tick();
        idle(); tick();

        do_load(5'd7, 3'b000, 2'd3, 32'h80FF_0000, 0, 5'd7);
        do_load(5'd7, 3'b100, 2'd3, 32'h80FF_0000, 0, 5'd7);
        do_load(5'd7, 3'b101, 2'd2, 32'h80FF_0000, 0, 5'd7);
        do_load(5'd7, 3'b001, 2'd2, 32'h80FF_0000, 0, 5'd3);
        do_load(5'd0, 3'b010, 2'd0, 32'h1234_5678, 0, 5'd0);
        do_load(5'd4, 3'b010, 2'd2, 32'h1234_5678, 0, 5'd4);
        do_load(5'd4, 3'b010, 2'd0, 32'h1234_5678, 1, 5'd4);
        do_load(5'd4, 3'b011, 2'd0, 32'h1234_5678, 0, 5'd4);
        do_load(5'd6, 3'b001, 2'd1, 32'h1234_5678, 0, 5'd6);

        exu(5'd8, 1, 0, 1, 3'b010, 2'd0); tick();
        idle(); tick();
        rst = 1; tick();
        rst = 0; lsu_rvalid = 1; lsu_rdata = 32'hFFFF_FFFF; tick();
        idle(); tick();

        for (int i = 0; i < 600; i++) begin
            if (!(exu_valid && !last_ready)) begin
                exu_valid     = ($urandom_range(0, 2) != 0);
                exu_rd        = 5'($urandom_range(0, 7));
                exu_wen       = ($urandom_range(0, 7) != 0);
                exu_data      = $urandom;
                exu_is_load   = ($urandom_range(0, 2) == 0);
                exu_ld_funct3 = 3'($urandom_range(0, 7));
                exu_addr_lo   = 2'($urandom_range(0, 3));
            end
            lsu_rvalid = ($urandom_range(0, 2) == 0);
            lsu_rerr   = ($urandom_range(0, 7) == 0);
            lsu_rdata  = $urandom;
            hz_raddr1  = 5'($urandom_range(0, 7));
            hz_raddr2  = 5'($urandom_range(0, 7));
            rst        = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
